// File: rtl/pipe_reg_slice_pkg.sv
// Shared definitions for the pipeline register slice: mode selectors and
// the per-stage occupancy encoding.
package pipe_reg_slice_pkg;

    localparam int RS_MODE_FULL = 0;
    localparam int RS_MODE_FWD  = 1;

    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_BUSY  = 2'd1,
        RS_FULL  = 2'd2
    } rs_state_e;

endpackage

// File: rtl/pipe_reg_slice_stage.sv
// One valid/ready register slice. MODE selects a fully registered 2-entry
// skid stage or a forward-only single register with combinational ready.
module pipe_reg_slice_stage
    import pipe_reg_slice_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               MODE  = RS_MODE_FULL,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             i_clock,
    input  logic             i_areset,
    input  logic             i_flush,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    // Handshake: a beat moves on a rising edge only when valid and ready are
    // both high; a presented beat is never withdrawn by this stage.
    if (MODE == RS_MODE_FULL) begin : g_full
        rs_state_e        r_state;
        rs_state_e        w_next_state;
        logic             r_s_ready;
        logic [WIDTH-1:0] r_main;
        logic [WIDTH-1:0] r_skid;
        logic             w_s_fire;

        assign w_s_fire = i_s_valid & r_s_ready;

        always_comb begin
            w_next_state = r_state;
            case (r_state)
                RS_EMPTY: begin
                    if (w_s_fire) w_next_state = RS_BUSY;
                end
                RS_BUSY: begin
                    if (w_s_fire && !i_m_ready)      w_next_state = RS_FULL;
                    else if (!w_s_fire && i_m_ready) w_next_state = RS_EMPTY;
                end
                RS_FULL: begin
                    if (i_m_ready) w_next_state = RS_BUSY;
                end
                default: w_next_state = RS_EMPTY;
            endcase
            if (i_flush) w_next_state = RS_EMPTY;
        end

        // Ready is registered so the upstream never sees a combinational path
        // through this stage; it is low only while both entries are occupied.
        always_ff @(posedge i_clock or posedge i_areset) begin
            if (i_areset) begin
                r_state   <= RS_EMPTY;
                r_s_ready <= 1'b0;
            end else begin
                r_state   <= w_next_state;
                r_s_ready <= (w_next_state != RS_FULL);
            end
        end

        always_ff @(posedge i_clock or posedge i_areset) begin
            if (i_areset) begin
                r_main <= RESET;
                r_skid <= RESET;
            end else if (!i_flush) begin
                case (r_state)
                    RS_EMPTY: begin
                        if (w_s_fire) r_main <= i_s_data;
                    end
                    RS_BUSY: begin
                        if (w_s_fire && i_m_ready)       r_main <= i_s_data;
                        else if (w_s_fire && !i_m_ready) r_skid <= i_s_data;
                    end
                    RS_FULL: begin
                        if (i_m_ready) r_main <= r_skid;
                    end
                    default: ;
                endcase
            end
        end

        assign o_s_ready = r_s_ready;
        assign o_m_valid = (r_state != RS_EMPTY);
        assign o_m_data  = r_main;
    end else begin : g_fwd
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             w_s_ready;
        logic             w_load;

        assign w_s_ready = i_m_ready | ~r_valid;
        assign w_load    = i_s_valid & w_s_ready;

        always_ff @(posedge i_clock or posedge i_areset) begin
            if (i_areset) begin
                r_valid <= 1'b0;
                r_data  <= RESET;
            end else begin
                if (i_flush)        r_valid <= 1'b0;
                else if (w_load)    r_valid <= 1'b1;
                else if (i_m_ready) r_valid <= 1'b0;
                if (w_load && !i_flush) r_data <= i_s_data;
            end
        end

        assign o_s_ready = w_s_ready;
        assign o_m_valid = r_valid;
        assign o_m_data  = r_data;
    end

endmodule

// File: rtl/pipe_reg_slice.sv
// Chain of STAGES valid/ready register slices between source (s) and sink
// (m); STAGES = 0 degenerates to plain wires.
module pipe_reg_slice
    import pipe_reg_slice_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               STAGES = 1,
    parameter int               MODE   = RS_MODE_FULL,
    parameter logic [WIDTH-1:0] RESET  = '0
) (
    input  logic             i_clock,
    input  logic             i_areset,
    input  logic             i_flush,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    if (STAGES == 0) begin : g_bypass
        logic w_unused_bypass;

        assign w_unused_bypass = i_clock ^ i_areset ^ i_flush;
        assign o_m_valid       = i_s_valid;
        assign o_m_data        = i_s_data;
        assign o_s_ready       = i_m_ready;
    end else begin : g_chain
        // Index g is the boundary feeding stage g; index STAGES is the sink.
        logic             w_valid [STAGES+1];
        logic             w_ready [STAGES+1];
        logic [WIDTH-1:0] w_data  [STAGES+1];

        assign w_valid[0]      = i_s_valid;
        assign w_data[0]       = i_s_data;
        assign o_s_ready       = w_ready[0];
        assign w_ready[STAGES] = i_m_ready;
        assign o_m_valid       = w_valid[STAGES];
        assign o_m_data        = w_data[STAGES];

        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            pipe_reg_slice_stage #(
                .WIDTH (WIDTH),
                .MODE  (MODE),
                .RESET (RESET)
            ) u_stage (
                .i_clock   (i_clock),
                .i_areset  (i_areset),
                .i_flush   (i_flush),
                .i_s_valid (w_valid[g]),
                .o_s_ready (w_ready[g]),
                .i_s_data  (w_data[g]),
                .o_m_valid (w_valid[g+1]),
                .i_m_ready (w_ready[g+1]),
                .o_m_data  (w_data[g+1])
            );
        end
    end

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Bench for pipe_reg_slice: several configurations side by side, directed
// steps plus a random handshake phase, each DUT tracked by an expected queue.
module tb_pipe_reg_slice;

    localparam int NCFG = 7;
    localparam int          CFG_STAGES [NCFG] = '{2, 3, 0, 1, 4, 1, 4};
    localparam int          CFG_MODE   [NCFG] = '{0, 0, 0, 0, 0, 1, 1};
    localparam logic [31:0] CFG_RESET  [NCFG] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0,
                                                 32'h0, 32'h0, 32'h0, 32'h0};

    logic        clk;
    logic        rst;
    logic        flush   [NCFG];
    logic        s_valid [NCFG];
    logic        s_ready [NCFG];
    logic [31:0] s_data  [NCFG];
    logic        m_valid [NCFG];
    logic        m_ready [NCFG];
    logic [31:0] m_data  [NCFG];

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUTs and scoreboards ----------------
    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        pipe_reg_slice #(
            .WIDTH  (32),
            .STAGES (CFG_STAGES[k]),
            .MODE   (CFG_MODE[k]),
            .RESET  (CFG_RESET[k])
        ) u_dut (
            .i_clock   (clk),
            .i_areset  (rst),
            .i_flush   (flush[k]),
            .i_s_valid (s_valid[k]),
            .o_s_ready (s_ready[k]),
            .i_s_data  (s_data[k]),
            .o_m_valid (m_valid[k]),
            .i_m_ready (m_ready[k]),
            .o_m_data  (m_data[k])
        );

        logic [31:0] exp_q[$];
        logic        prev_hold;
        logic [31:0] prev_data;
        int          n_out = 0;
        logic [31:0] exp_v;

        // Inputs change just after the rising edge, so the values seen on the
        // falling edge are the ones the next rising edge will act on.
        initial begin
            prev_hold = 1'b0;
            prev_data = '0;
            forever begin
                @(negedge clk or posedge rst);
                if (rst) begin
                    exp_q.delete();
                    prev_hold = 1'b0;
                end else if (flush[k] && CFG_STAGES[k] != 0) begin
                    exp_q.delete();
                    prev_hold = 1'b0;
                end else begin
                    if (prev_hold) begin
                        chk($sformatf("hold_valid_cfg%0d", k), 32'(m_valid[k]), 32'd1);
                        chk($sformatf("hold_data_cfg%0d", k), m_data[k], prev_data);
                    end
                    if (s_valid[k] && s_ready[k]) exp_q.push_back(s_data[k]);
                    if (m_valid[k] && m_ready[k]) begin
                        chk($sformatf("sb_nonempty_cfg%0d", k), 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            exp_v = exp_q.pop_front();
                            chk($sformatf("sb_data_cfg%0d", k), m_data[k], exp_v);
                            n_out++;
                        end
                    end
                    prev_hold = m_valid[k] && !m_ready[k];
                    prev_data = m_data[k];
                end
            end
        end
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        bit acc [NCFG];

        rst = 1'b1;
        for (int k = 0; k < NCFG; k++) begin
            flush[k]   = 1'b0;
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b0;
            acc[k]     = 1'b0;
        end

        // Reset values
        repeat (2) tick();
        chk("rst_m_valid", 32'(m_valid[0]), 32'd0);
        chk("rst_m_data", m_data[0], 32'hDEAD_BEEF);
        chk("rst_m_data_cfg1", m_data[1], 32'h0BAD_F00D);
        chk("rst_s_ready_full", 32'(s_ready[0]), 32'd0);
        chk("rst_s_ready_fwd", 32'(s_ready[5]), 32'd1);
        rst = 1'b0;
        #1;
        chk("rel_s_ready_before_edge", 32'(s_ready[0]), 32'd0);
        tick();
        chk("rel_s_ready_after_edge", 32'(s_ready[0]), 32'd1);
        chk("rel_s_ready_cfg1", 32'(s_ready[1]), 32'd1);

        // Single-beat latency: STAGES=3 FULL and STAGES=4 FWD
        s_valid[1] = 1'b1; s_data[1] = 32'h1234; m_ready[1] = 1'b1;
        s_valid[6] = 1'b1; s_data[6] = 32'h5678; m_ready[6] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            s_valid[1] = 1'b0;
            s_valid[6] = 1'b0;
            chk($sformatf("lat_full_valid_c%0d", c), 32'(m_valid[1]), 32'(c == 3));
            if (c == 3) chk("lat_full_data", m_data[1], 32'h1234);
            chk($sformatf("lat_fwd_valid_c%0d", c), 32'(m_valid[6]), 32'(c == 4));
            if (c == 4) chk("lat_fwd_data", m_data[6], 32'h5678);
        end

        // Back-to-back stream 0..99 through STAGES=4, both modes
        m_ready[4] = 1'b1;
        m_ready[6] = 1'b1;
        for (int j = 0; j < 106; j++) begin
            chk($sformatf("strm_full_valid_%0d", j), 32'(m_valid[4]), 32'(j >= 4 && j < 104));
            chk($sformatf("strm_fwd_valid_%0d", j), 32'(m_valid[6]), 32'(j >= 4 && j < 104));
            if (j >= 4 && j < 104) begin
                chk($sformatf("strm_full_data_%0d", j), m_data[4], 32'(j - 4));
                chk($sformatf("strm_fwd_data_%0d", j), m_data[6], 32'(j - 4));
            end
            if (j < 100) begin
                chk($sformatf("strm_full_ready_%0d", j), 32'(s_ready[4]), 32'd1);
                chk($sformatf("strm_fwd_ready_%0d", j), 32'(s_ready[6]), 32'd1);
            end
            s_valid[4] = (j < 100);
            s_valid[6] = (j < 100);
            s_data[4]  = 32'(j);
            s_data[6]  = 32'(j);
            tick();
        end
        s_valid[4] = 1'b0;
        s_valid[6] = 1'b0;

        // Back-pressure on STAGES=2 FULL: ready drops after exactly 4 beats
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_s_ready_%0d", i), 32'(s_ready[0]), 32'(i < 4));
            if (i >= 2) begin
                chk($sformatf("bp_m_valid_%0d", i), 32'(m_valid[0]), 32'd1);
                chk($sformatf("bp_m_data_%0d", i), m_data[0], 32'hA0);
            end
            s_valid[0] = 1'b1;
            s_data[0]  = 32'hA0 + 32'((i < 4) ? i : 4);
            tick();
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("drain_valid_%0d", c), 32'(m_valid[0]), 32'd1);
            chk($sformatf("drain_data_%0d", c), m_data[0], 32'hA0 + 32'(c));
            tick();
        end
        chk("drain_empty", 32'(m_valid[0]), 32'd0);
        m_ready[0] = 1'b0;

        // Random valid/ready on STAGES {0,1,4} in both modes
        for (int k = 2; k < NCFG; k++) begin
            s_valid[k] = 1'b0;
            s_data[k]  = 32'(k) << 24;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int k = 2; k < NCFG; k++) acc[k] = s_valid[k] && s_ready[k];
            tick();
            for (int k = 2; k < NCFG; k++) begin
                if (acc[k]) s_data[k] = s_data[k] + 32'd1;
                if (!(s_valid[k] && !acc[k])) s_valid[k] = ($urandom_range(0, 3) != 0);
                m_ready[k] = ($urandom_range(0, 3) != 0);
            end
        end
        for (int k = 2; k < NCFG; k++) begin
            s_valid[k] = 1'b0;
            m_ready[k] = 1'b1;
        end
        repeat (30) tick();
        chk("rand_left_cfg2", 32'(g_dut[2].exp_q.size()), 32'd0);
        chk("rand_left_cfg3", 32'(g_dut[3].exp_q.size()), 32'd0);
        chk("rand_left_cfg4", 32'(g_dut[4].exp_q.size()), 32'd0);
        chk("rand_left_cfg5", 32'(g_dut[5].exp_q.size()), 32'd0);
        chk("rand_left_cfg6", 32'(g_dut[6].exp_q.size()), 32'd0);
        chk("rand_progress_cfg2", 32'(g_dut[2].n_out > 1000), 32'd1);
        chk("rand_progress_cfg3", 32'(g_dut[3].n_out > 1000), 32'd1);
        chk("rand_progress_cfg4", 32'(g_dut[4].n_out > 1000), 32'd1);
        chk("rand_progress_cfg5", 32'(g_dut[5].n_out > 1000), 32'd1);
        chk("rand_progress_cfg6", 32'(g_dut[6].n_out > 1000), 32'd1);

        // Flush with 3 beats held and a new beat offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fl_fill_ready_%0d", i), 32'(s_ready[0]), 32'd1);
            s_valid[0] = 1'b1;
            s_data[0]  = 32'hB0 + 32'(i);
            tick();
        end
        s_data[0] = 32'hBF;
        flush[0]  = 1'b1;
        tick();
        flush[0]   = 1'b0;
        s_valid[0] = 1'b0;
        chk("fl_m_valid", 32'(m_valid[0]), 32'd0);
        chk("fl_s_ready", 32'(s_ready[0]), 32'd1);
        chk("fl_payload_kept", m_data[0], 32'hB0);
        m_ready[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("fl_no_beat_%0d", c), 32'(m_valid[0]), 32'd0);
            tick();
        end

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 32'hC0 + 32'(i);
            tick();
        end
        chk("ar_streaming", 32'(m_valid[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_m_valid", 32'(m_valid[0]), 32'd0);
        chk("ar_m_data", m_data[0], 32'hDEAD_BEEF);
        chk("ar_s_ready", 32'(s_ready[0]), 32'd0);
        s_valid[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("ar_rel_s_ready", 32'(s_ready[0]), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ar_no_stale_%0d", c), 32'(m_valid[0]), 32'd0);
            tick();
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
